// File: rtl/csa_accum_driver.sv
// csa_accum_driver: initiator for a carry-save accumulator's operand/terminate interface.
//
// Buffers host operand beats ({last, data}) in a small FIFO, issues one accumulate pulse per
// operand, then on the batch's last operand settles, pulses terminate, waits for done,
// captures the result for the host and finally clears the accumulator for the next batch.
//
// Ports:
//   iClk, iRstN          clock, asynchronous active-low reset
//   iData/iLast/iValid   host operand stream in; oReady = FIFO not full (registered)
//   oA/oAccumulate       operand and one-cycle add request to the accumulator
//   oTerminate           one-cycle finish request to the accumulator
//   oAccRst              active-high synchronous clear to the accumulator
//   iAccReady/iAccDone   accumulator ready level and done pulse
//   iAccRes              accumulator result
//   oRes/oCount          captured batch sum and operand count
//   oResValid/iResReady  result handshake to the host
//   oErr                 sticky done-watchdog error
//
// Optional feature: define CSA_ACCUM_DRIVER_TIMEOUT_EN to bound WAIT by TIMEOUT_CYCLES cycles;
// otherwise WAIT is unbounded and oErr is tied low.

module csa_accum_driver #(
    parameter int unsigned INPUT_LENGTH   = 16,
    parameter int unsigned OUTPUT_LENGTH  = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned COUNT_WIDTH    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     iClk,
    input  logic                     iRstN,
    input  logic [INPUT_LENGTH-1:0]  iData,
    input  logic                     iLast,
    input  logic                     iValid,
    output logic                     oReady,
    output logic [INPUT_LENGTH-1:0]  oA,
    output logic                     oAccumulate,
    output logic                     oTerminate,
    output logic                     oAccRst,
    input  logic                     iAccReady,
    input  logic                     iAccDone,
    input  logic [OUTPUT_LENGTH-1:0] iAccRes,
    output logic [OUTPUT_LENGTH-1:0] oRes,
    output logic [COUNT_WIDTH-1:0]   oCount,
    output logic                     oResValid,
    input  logic                     iResReady,
    output logic                     oErr
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned FillW = PtrW + 1;

    typedef enum logic [2:0] {
        StIdle, StIssue, StSettle, StTerm, StWait, StResult, StClear
    } state_e;

    state_e state_q;

    // ---------------- operand FIFO ----------------
    logic [INPUT_LENGTH:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [FillW-1:0]      fill_q, fill_d;
    logic                  ready_q;
    logic                  push, pop, empty;
    logic [INPUT_LENGTH:0] head;

    assign empty = (fill_q == '0);
    assign push  = iValid && ready_q;
    assign pop   = (state_q == StIssue) && !empty && iAccReady;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + FillW'(1);
        end else if (!push && pop) begin
            fill_d = fill_q - FillW'(1);
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            fill_q  <= fill_d;
            ready_q <= (fill_d != FillW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge iClk) begin
        if (push) mem_q[wr_ptr_q] <= {iLast, iData};
    end

    // ---------------- sequencing FSM ----------------
    logic [COUNT_WIDTH-1:0]   count_q;
    logic [COUNT_WIDTH-1:0]   res_cnt_q;
    logic [OUTPUT_LENGTH-1:0] res_q;
    logic [INPUT_LENGTH-1:0]  a_q;
    logic                     acc_q, term_q, acc_rst_q, rst_pend_q, res_valid_q;

`ifdef CSA_ACCUM_DRIVER_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TimerW-1:0] timer_q;
    logic              err_q;
`endif

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q     <= StIdle;
            count_q     <= '0;
            res_cnt_q   <= '0;
            res_q       <= '0;
            a_q         <= '0;
            acc_q       <= 1'b0;
            term_q      <= 1'b0;
            acc_rst_q   <= 1'b1;
            rst_pend_q  <= 1'b1;
            res_valid_q <= 1'b0;
`ifdef CSA_ACCUM_DRIVER_TIMEOUT_EN
            timer_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            acc_q      <= 1'b0;
            term_q     <= 1'b0;
            rst_pend_q <= 1'b0;
            // Keep the accumulator clear asserted through the first clock after reset release.
            acc_rst_q  <= rst_pend_q;
`ifdef CSA_ACCUM_DRIVER_TIMEOUT_EN
            timer_q    <= (state_q == StWait) ? timer_q + TimerW'(1) : '0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (!empty && iAccReady) state_q <= StIssue;
                end
                StIssue: begin
                    if (pop) begin
                        acc_q <= 1'b1;
                        a_q   <= head[INPUT_LENGTH-1:0];
                        if (count_q != '1) count_q <= count_q + COUNT_WIDTH'(1);
                        if (head[INPUT_LENGTH]) state_q <= StSettle;
                    end
                end
                // Idle cycle so the final operand is absorbed before terminate.
                StSettle: state_q <= StTerm;
                StTerm: begin
                    term_q  <= 1'b1;
                    state_q <= StWait;
                end
                StWait: begin
                    if (iAccDone) begin
                        res_q       <= iAccRes;
                        res_cnt_q   <= count_q;
                        res_valid_q <= 1'b1;
                        state_q     <= StResult;
                    end
`ifdef CSA_ACCUM_DRIVER_TIMEOUT_EN
                    else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                        err_q       <= 1'b1;
                        res_q       <= '0;
                        res_cnt_q   <= count_q;
                        res_valid_q <= 1'b1;
                        state_q     <= StResult;
                    end
`endif
                end
                StResult: begin
                    if (iResReady) begin
                        res_valid_q <= 1'b0;
                        count_q     <= '0;
                        acc_rst_q   <= 1'b1;
                        state_q     <= StClear;
                    end
                end
                StClear: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign oReady      = ready_q;
    assign oA          = a_q;
    assign oAccumulate = acc_q;
    assign oTerminate  = term_q;
    assign oAccRst     = acc_rst_q;
    assign oRes        = res_q;
    assign oCount      = res_cnt_q;
    assign oResValid   = res_valid_q;
`ifdef CSA_ACCUM_DRIVER_TIMEOUT_EN
    assign oErr        = err_q;
`else
    assign oErr        = 1'b0;
`endif

endmodule

// File: tb/tb_csa_accum_driver.sv
// Self-checking bench for csa_accum_driver with a small behavioural accumulator responder.

module tb_csa_accum_driver;

    localparam int unsigned IW = 16;
    localparam int unsigned OW = 32;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] data;
    logic          last;
    logic          valid;
    logic          ready;
    logic [IW-1:0] a;
    logic          accumulate;
    logic          terminate;
    logic          acc_rst;
    logic          acc_ready;
    logic          acc_done = 1'b0;
    logic [OW-1:0] acc_res = '0;
    logic [OW-1:0] res;
    logic [CW-1:0] count;
    logic          res_valid;
    logic          res_ready;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_accum_driver dut (
        .iClk        (clk),
        .iRstN       (rst_n),
        .iData       (data),
        .iLast       (last),
        .iValid      (valid),
        .oReady      (ready),
        .oA          (a),
        .oAccumulate (accumulate),
        .oTerminate  (terminate),
        .oAccRst     (acc_rst),
        .iAccReady   (acc_ready),
        .iAccDone    (acc_done),
        .iAccRes     (acc_res),
        .oRes        (res),
        .oCount      (count),
        .oResValid   (res_valid),
        .iResReady   (res_ready),
        .oErr        (err)
    );

    // Cycle stamp and output logs, sampled on the falling edge.
    int            cyc = 0;
    logic [IW-1:0] acc_log [256];
    int            acc_cyc [256];
    int            acc_n = 0;
    int            term_n = 0;
    int            term_cyc = 0;
    int            rst_cnt = 0;
    int            both_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (accumulate && acc_n < 256) begin
            acc_log[acc_n] = a;
            acc_cyc[acc_n] = cyc;
            acc_n++;
        end
        if (terminate) begin
            term_n++;
            term_cyc = cyc;
        end
        if (acc_rst) rst_cnt++;
        if (accumulate && terminate) both_cnt++;
    end

    // Accumulator responder: sums operands, answers terminate with done three cycles later.
    logic [OW-1:0] sum = '0;
    int            done_dly = 0;
    logic          done_en;

    always @(posedge clk) begin
        acc_done <= 1'b0;
        if (acc_rst) sum <= '0;
        else if (accumulate) sum <= sum + OW'(a);
        if (terminate && done_en) begin
            done_dly <= 3;
        end else if (done_dly != 0) begin
            done_dly <= done_dly - 1;
            if (done_dly == 1) begin
                acc_done <= 1'b1;
                acc_res  <= sum;
            end
        end
    end

    task automatic push_beat(input logic [IW-1:0] d, input logic l);
        int g;
        data  = d;
        last  = l;
        valid = 1'b1;
        g = 0;
        while (!ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL push_beat: ready=%0b for beat %0h, required 1 within 300 cycles", ready, d);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_result();
        int g;
        g = 0;
        @(negedge clk);
        while (!res_valid && g < 500) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_result: res_valid=%0b, required 1 within 500 cycles", res_valid);
        end
    endtask

    task automatic accept_result();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        data      = '0;
        last      = 1'b0;
        valid     = 1'b0;
        res_ready = 1'b0;
        acc_ready = 1'b1;
        done_en   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({res_valid, accumulate, terminate, err, acc_rst} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctrl: {vld,acc,term,err,accrst}=%b, required 00001",
                     {res_valid, accumulate, terminate, err, acc_rst});
        end
        checks++;
        if ({a, res, count} !== '0) begin
            errors++;
            $display("FAIL reset_data: a=%0h res=%0h count=%0d, required 0", a, res, count);
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready=%0b, required 1", ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (acc_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_accrst_hold: acc_rst=%0b, required 1", acc_rst);
        end
        @(negedge clk);
        checks++;
        if (acc_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_accrst_release: acc_rst=%0b, required 0", acc_rst);
        end
    endtask

    task automatic test_basic_batch();
        int b;
        int t0;
        int r0;
        b  = acc_n;
        t0 = term_n;
        push_beat(16'd3, 1'b0);
        push_beat(16'd5, 1'b0);
        push_beat(16'd7, 1'b1);
        wait_result();
        checks++;
        if (acc_n - b != 3) begin
            errors++;
            $display("FAIL basic_acc_count: pulses=%0d, required 3", acc_n - b);
        end
        checks++;
        if (acc_log[b] !== 16'd3 || acc_log[b+1] !== 16'd5 || acc_log[b+2] !== 16'd7) begin
            errors++;
            $display("FAIL basic_operands: a=%0d,%0d,%0d, required 3,5,7",
                     acc_log[b], acc_log[b+1], acc_log[b+2]);
        end
        checks++;
        if (acc_cyc[b+1] != acc_cyc[b] + 1 || acc_cyc[b+2] != acc_cyc[b+1] + 1) begin
            errors++;
            $display("FAIL basic_back_to_back: cycles %0d,%0d,%0d, required consecutive",
                     acc_cyc[b], acc_cyc[b+1], acc_cyc[b+2]);
        end
        checks++;
        if (term_n - t0 != 1 || term_cyc - acc_cyc[b+2] != 2) begin
            errors++;
            $display("FAIL basic_terminate: pulses=%0d gap=%0d, required 1 pulse gap 2",
                     term_n - t0, term_cyc - acc_cyc[b+2]);
        end
        checks++;
        if (res !== 32'd15 || count !== 8'd3) begin
            errors++;
            $display("FAIL basic_result: res=%0d count=%0d, required 15 3", res, count);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res !== 32'd15) begin
                errors++;
                $display("FAIL basic_hold: res_valid=%0b res=%0d, required 1 15", res_valid, res);
            end
        end
        r0 = rst_cnt;
        accept_result();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || acc_rst !== 1'b1) begin
            errors++;
            $display("FAIL basic_accept: res_valid=%0b acc_rst=%0b, required 0 1", res_valid, acc_rst);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rst_cnt - r0 != 1) begin
            errors++;
            $display("FAIL basic_clear_pulse: acc_rst cycles=%0d, required 1", rst_cnt - r0);
        end
    endtask

    task automatic test_two_batches();
        push_beat(16'hFFFF, 1'b0);
        push_beat(16'h0001, 1'b1);
        push_beat(16'h0002, 1'b1);
        wait_result();
        checks++;
        if (res !== 32'h0001_0000 || count !== 8'd2) begin
            errors++;
            $display("FAIL two_batch_first: res=%0h count=%0d, required 10000 2", res, count);
        end
        accept_result();
        wait_result();
        checks++;
        if (res !== 32'd2 || count !== 8'd1) begin
            errors++;
            $display("FAIL two_batch_second: res=%0h count=%0d, required 2 1", res, count);
        end
        accept_result();
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        push_beat(16'd1, 1'b0);
        push_beat(16'd2, 1'b1);
        push_beat(16'd10, 1'b0);
        push_beat(16'd20, 1'b0);
        push_beat(16'd30, 1'b1);
        push_beat(16'd100, 1'b1);
        wait_result();
        checks++;
        if (res !== 32'd3 || count !== 8'd2) begin
            errors++;
            $display("FAIL bp_first: res=%0d count=%0d, required 3 2", res, count);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: ready=%0b, required 0", ready);
        end
        accept_result();
        wait_result();
        checks++;
        if (res !== 32'd60 || count !== 8'd3) begin
            errors++;
            $display("FAIL bp_second: res=%0d count=%0d, required 60 3", res, count);
        end
        accept_result();
        wait_result();
        checks++;
        if (res !== 32'd100 || count !== 8'd1) begin
            errors++;
            $display("FAIL bp_third: res=%0d count=%0d, required 100 1", res, count);
        end
        accept_result();
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drained: ready=%0b, required 1", ready);
        end
    endtask

    task automatic test_acc_ready_stall();
        int b;
        b = acc_n;
        acc_ready = 1'b0;
        push_beat(16'd1, 1'b0);
        push_beat(16'd2, 1'b0);
        push_beat(16'd3, 1'b0);
        push_beat(16'd4, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (acc_n - b != 0) begin
            errors++;
            $display("FAIL stall_idle: pulses=%0d while not ready, required 0", acc_n - b);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        acc_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (accumulate !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: accumulate=%0b while not ready, required 0", accumulate);
            end
        end
        checks++;
        if (acc_n - b != 1) begin
            errors++;
            $display("FAIL stall_progress: pulses=%0d, required 1", acc_n - b);
        end
        acc_ready = 1'b1;
        wait_result();
        checks++;
        if (acc_n - b != 4 || acc_log[b] !== 16'd1 || acc_log[b+1] !== 16'd2 ||
            acc_log[b+2] !== 16'd3 || acc_log[b+3] !== 16'd4) begin
            errors++;
            $display("FAIL stall_operands: n=%0d a=%0d,%0d,%0d,%0d, required 4 1,2,3,4",
                     acc_n - b, acc_log[b], acc_log[b+1], acc_log[b+2], acc_log[b+3]);
        end
        checks++;
        if (res !== 32'd10 || count !== 8'd4) begin
            errors++;
            $display("FAIL stall_result: res=%0d count=%0d, required 10 4", res, count);
        end
        accept_result();
    endtask

    task automatic test_reset_in_wait();
        int t0;
        int g;
        done_en = 1'b0;
        t0 = term_n;
        push_beat(16'd9, 1'b1);
        g = 0;
        while (term_n == t0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (term_n == t0) begin
            errors++;
            $display("FAIL rstwait_term: terminate pulses=0, required 1 within 100 cycles");
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, accumulate, terminate, err, acc_rst} !== 5'b00001) begin
            errors++;
            $display("FAIL rstwait_ctrl: {vld,acc,term,err,accrst}=%b, required 00001",
                     {res_valid, accumulate, terminate, err, acc_rst});
        end
        checks++;
        if ({a, res, count} !== '0) begin
            errors++;
            $display("FAIL rstwait_data: a=%0h res=%0h count=%0d, required 0", a, res, count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        done_en = 1'b1;
        repeat (3) @(negedge clk);
        push_beat(16'd4, 1'b0);
        push_beat(16'd6, 1'b1);
        wait_result();
        checks++;
        if (res !== 32'd10 || count !== 8'd2) begin
            errors++;
            $display("FAIL rstwait_next: res=%0d count=%0d, required 10 2", res, count);
        end
        accept_result();
    endtask

`ifdef CSA_ACCUM_DRIVER_TIMEOUT_EN
    task automatic test_timeout();
        done_en = 1'b0;
        push_beat(16'd5, 1'b1);
        wait_result();
        checks++;
        if (err !== 1'b1 || res !== 32'd0 || count !== 8'd1) begin
            errors++;
            $display("FAIL timeout_result: err=%0b res=%0d count=%0d, required 1 0 1", err, res, count);
        end
        accept_result();
        done_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err=%0b, required 1", err);
        end
    endtask
`endif

    task automatic test_final();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL acc_term_overlap: cycles=%0d, required 0", both_cnt);
        end
`ifndef CSA_ACCUM_DRIVER_TIMEOUT_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_tied: err=%0b, required 0", err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_batch();
        test_two_batches();
        test_backpressure();
        test_acc_ready_stall();
        test_reset_in_wait();
`ifdef CSA_ACCUM_DRIVER_TIMEOUT_EN
        test_timeout();
`endif
        test_final();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
